// File: rtl/medidor_sonar_duplo.sv
// Dual ultrasonic ranger sequencer: fires left then right HC-SR04 style sensors,
// converts each echo width to 3-digit BCD centimetres and presents both as one pair.
// Latency: 2-cycle echo synchronizer; pair published one cycle after right echo falls.
// Backpressure: none; medir is sampled only in INICIAL, requests elsewhere are dropped.
//
// Ports:
//   clock, reset (async active-low)
//   medir                    - start request
//   echo_esq / echo_dir      - asynchronous sensor echoes
//   trigger_esq / trigger_dir- sensor trigger pulses (registered)
//   medida_esq / medida_dir  - BCD cm results, {hundreds, tens, units}
//   pronto                   - one-cycle strobe when a new pair is published
//   timeout_esq / timeout_dir- last measurement on that side timed out
//   db_estado                - FSM state encoding
//
// Optional build macro: MEDIDOR_ARREDONDA_EN - preload the cm divider with half a
// centimetre so results round half-up instead of truncating.

module medidor_sonar_duplo #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int PAUSA_CYCLES   = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo_esq,
    input  logic        echo_dir,
    output logic        trigger_esq,
    output logic        trigger_dir,
    output logic [11:0] medida_esq,
    output logic [11:0] medida_dir,
    output logic        pronto,
    output logic        timeout_esq,
    output logic        timeout_dir,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        TRIG_ESQ   = 4'd1,
        ESPERA_ESQ = 4'd2,
        MEDE_ESQ   = 4'd3,
        PAUSA      = 4'd4,
        TRIG_DIR   = 4'd5,
        ESPERA_DIR = 4'd6,
        MEDE_DIR   = 4'd7,
        FINAL      = 4'd8
    } estado_t;

    localparam logic [11:0] LONGE      = 12'h999;
    localparam logic [31:0] TRIG_LAST  = 32'(TRIGGER_CYCLES - 1);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] PAUSA_LAST = 32'(PAUSA_CYCLES - 1);
    localparam logic [31:0] DIV_LAST   = 32'(CYCLES_PER_CM - 1);
`ifdef MEDIDOR_ARREDONDA_EN
    localparam logic [31:0] DIV_INIT   = 32'(CYCLES_PER_CM / 2);
`else
    localparam logic [31:0] DIV_INIT   = 32'd0;
`endif

    // BCD +1 with carry through tens and hundreds, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == LONGE) begin
            r = v;
        end else if (v[3:0] != 4'h9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'h0;
            if (v[7:4] != 4'h9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'h0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    // Two-flop synchronizers; all echo timing uses the *_s2_q versions.
    logic esq_s1_q, esq_s2_q, dir_s1_q, dir_s2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            esq_s1_q <= 1'b0;
            esq_s2_q <= 1'b0;
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
        end else begin
            esq_s1_q <= echo_esq;
            esq_s2_q <= esq_s1_q;
            dir_s1_q <= echo_dir;
            dir_s2_q <= dir_s1_q;
        end
    end

    estado_t     state_q, state_d;
    logic [31:0] cnt_q, cnt_d;           // shared cycle counter: trigger, wait, echo, pause
    logic [31:0] div_q, div_d;           // echo cycles within the current centimetre
    logic [11:0] bcd_q, bcd_d;           // running cm count for the side being measured
    logic [11:0] res_esq_q, res_esq_d;
    logic [11:0] res_dir_q, res_dir_d;
    logic        tmo_esq_q, tmo_esq_d;
    logic        tmo_dir_q, tmo_dir_d;
    logic        trig_esq_q, trig_esq_d;
    logic        trig_dir_q, trig_dir_d;
    logic        pronto_q, pronto_d;
    logic [11:0] medida_esq_q, medida_esq_d;
    logic [11:0] medida_dir_q, medida_dir_d;
    logic        timeout_esq_q, timeout_esq_d;
    logic        timeout_dir_q, timeout_dir_d;

    logic        lado_dir;
    logic        echo_sel;
    logic        div_wrap;
    logic [31:0] div_step;
    logic [11:0] bcd_step;

    assign lado_dir = (state_q == ESPERA_DIR) || (state_q == MEDE_DIR);
    assign echo_sel = lado_dir ? dir_s2_q : esq_s2_q;
    // One echo-high cycle of progress through the cm divider.
    assign div_wrap = (div_q == DIV_LAST);
    assign div_step = div_wrap ? 32'd0 : div_q + 32'd1;
    assign bcd_step = div_wrap ? bcd_inc(bcd_q) : bcd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bcd_d     = bcd_q;
        res_esq_d = res_esq_q;
        res_dir_d = res_dir_q;
        tmo_esq_d = tmo_esq_q;
        tmo_dir_d = tmo_dir_q;

        unique case (state_q)
            INICIAL: begin
                cnt_d = 32'd0;
                if (medir) begin
                    state_d = TRIG_ESQ;
                end
            end

            TRIG_ESQ, TRIG_DIR: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = 32'd0;
                    div_d   = DIV_INIT;
                    bcd_d   = 12'h000;
                    state_d = (state_q == TRIG_ESQ) ? ESPERA_ESQ : ESPERA_DIR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ESPERA_ESQ, ESPERA_DIR: begin
                if (echo_sel) begin
                    // The detection cycle is itself the first echo-high cycle.
                    cnt_d   = 32'd1;
                    div_d   = div_step;
                    bcd_d   = bcd_step;
                    state_d = lado_dir ? MEDE_DIR : MEDE_ESQ;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = 32'd0;
                    if (lado_dir) begin
                        res_dir_d = LONGE;
                        tmo_dir_d = 1'b1;
                        state_d   = FINAL;
                    end else begin
                        res_esq_d = LONGE;
                        tmo_esq_d = 1'b1;
                        state_d   = PAUSA;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            MEDE_ESQ, MEDE_DIR: begin
                // cnt_q holds the echo-high cycles already counted.
                if (!echo_sel || (cnt_q >= TMO_LIMIT)) begin
                    cnt_d = 32'd0;
                    if (lado_dir) begin
                        res_dir_d = echo_sel ? LONGE : bcd_q;
                        tmo_dir_d = echo_sel;
                        state_d   = FINAL;
                    end else begin
                        res_esq_d = echo_sel ? LONGE : bcd_q;
                        tmo_esq_d = echo_sel;
                        state_d   = PAUSA;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    div_d = div_step;
                    bcd_d = bcd_step;
                end
            end

            PAUSA: begin
                if (cnt_q == PAUSA_LAST) begin
                    cnt_d   = 32'd0;
                    state_d = TRIG_DIR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            FINAL: begin
                cnt_d   = 32'd0;
                state_d = INICIAL;
            end

            default: begin
                cnt_d   = 32'd0;
                state_d = INICIAL;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with state_q.
    // The published pair only moves when FINAL is entered, keeping left/right coherent.
    always_comb begin
        trig_esq_d    = (state_d == TRIG_ESQ);
        trig_dir_d    = (state_d == TRIG_DIR);
        pronto_d      = (state_d == FINAL);
        medida_esq_d  = medida_esq_q;
        medida_dir_d  = medida_dir_q;
        timeout_esq_d = timeout_esq_q;
        timeout_dir_d = timeout_dir_q;
        if (state_d == FINAL) begin
            medida_esq_d  = res_esq_d;
            medida_dir_d  = res_dir_d;
            timeout_esq_d = tmo_esq_d;
            timeout_dir_d = tmo_dir_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= INICIAL;
            cnt_q         <= 32'd0;
            div_q         <= 32'd0;
            bcd_q         <= 12'h000;
            res_esq_q     <= LONGE;
            res_dir_q     <= LONGE;
            tmo_esq_q     <= 1'b0;
            tmo_dir_q     <= 1'b0;
            trig_esq_q    <= 1'b0;
            trig_dir_q    <= 1'b0;
            pronto_q      <= 1'b0;
            medida_esq_q  <= LONGE;
            medida_dir_q  <= LONGE;
            timeout_esq_q <= 1'b0;
            timeout_dir_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            bcd_q         <= bcd_d;
            res_esq_q     <= res_esq_d;
            res_dir_q     <= res_dir_d;
            tmo_esq_q     <= tmo_esq_d;
            tmo_dir_q     <= tmo_dir_d;
            trig_esq_q    <= trig_esq_d;
            trig_dir_q    <= trig_dir_d;
            pronto_q      <= pronto_d;
            medida_esq_q  <= medida_esq_d;
            medida_dir_q  <= medida_dir_d;
            timeout_esq_q <= timeout_esq_d;
            timeout_dir_q <= timeout_dir_d;
        end
    end

    assign trigger_esq = trig_esq_q;
    assign trigger_dir = trig_dir_q;
    assign pronto      = pronto_q;
    assign medida_esq  = medida_esq_q;
    assign medida_dir  = medida_dir_q;
    assign timeout_esq = timeout_esq_q;
    assign timeout_dir = timeout_dir_q;
    assign db_estado   = state_q;

endmodule

// File: doc/medidor_sonar_duplo.md
Name: medidor_sonar_duplo

Overview:
Sequencer for the left and right ultrasonic rangers (HC-SR04 style) feeding the proximity comparator stage.
- On a `medir` request it fires the left sensor, measures its echo, pauses, then fires the right sensor and measures its echo.
- Each echo width is converted to centimetres as 3-digit BCD (12 bits).
- Both results are presented together as `medida_esq` / `medida_dir`, with a one-cycle `pronto` strobe.

Parameters:
TRIGGER_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
CYCLES_PER_CM, 2941, clocks of echo-high per centimetre (58.82 us/cm at 50 MHz)
TIMEOUT_CYCLES, 1500000, max clocks waiting for echo rise, and max clocks of echo high
PAUSA_CYCLES, 500000, idle gap between left echo end and right trigger

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
medir  in  1  start request, sampled only in INICIAL
echo_esq  in  1  left sensor echo (asynchronous)
echo_dir  in  1  right sensor echo (asynchronous)
trigger_esq  out  1  left sensor trigger
trigger_dir  out  1  right sensor trigger
medida_esq  out  12  left distance, BCD cm [11:8] hundreds, [7:4] tens, [3:0] units
medida_dir  out  12  right distance, BCD cm
pronto  out  1  one-cycle strobe: new measurement pair valid
timeout_esq  out  1  last left measurement timed out
timeout_dir  out  1  last right measurement timed out
db_estado  out  4  current FSM state encoding, debug

Behaviour:
- Reset (`reset`=0, asynchronous):
  - FSM to INICIAL; triggers 0; `pronto` 0; timeout flags 0; all counters 0.
  - `medida_esq` = `medida_dir` = 12'h999 (far), so the downstream comparator never flags proximity out of reset.
  - Reset mid-measurement aborts immediately. Triggers drop in the same cycle.
- Echo inputs pass through a 2-flop synchronizer each. All echo timing is measured on the synchronized signal (2-cycle input latency).
- State encoding on `db_estado`:
  - INICIAL 0, TRIG_ESQ 1, ESPERA_ESQ 2, MEDE_ESQ 3, PAUSA 4, TRIG_DIR 5, ESPERA_DIR 6, MEDE_DIR 7, FINAL 8.
- INICIAL: if `medir`=1, go to TRIG_ESQ next cycle. `medir` is ignored in every other state; no queuing.
- TRIG_ESQ: `trigger_esq`=1 for exactly TRIGGER_CYCLES cycles (registered output), then ESPERA_ESQ.
- ESPERA_ESQ: wait for synchronized echo high, then go to MEDE_ESQ.
  - If TIMEOUT_CYCLES elapse with no echo: left result 12'h999, `timeout_esq`=1, go to PAUSA.
- MEDE_ESQ, cm counting:
  - A tick divider counts 0..CYCLES_PER_CM-1 while echo is high.
  - On wrap, the BCD counter increments; units→tens→hundreds carry.
  - Result = floor(echo_cycles / CYCLES_PER_CM).
  - The BCD counter saturates at 999 (no wrap to 000).
  - On echo falling: latch the internal left result, `timeout_esq`=0, go to PAUSA.
  - If echo stays high for TIMEOUT_CYCLES: result 12'h999, `timeout_esq`=1, go to PAUSA.
- PAUSA: PAUSA_CYCLES cycles, then TRIG_DIR. TRIG_DIR / ESPERA_DIR / MEDE_DIR mirror the left-side states using right-side signals.
- FINAL (one cycle):
  - `medida_esq` and `medida_dir` update simultaneously from the internal results.
  - Timeout flags update at the same time.
  - `pronto`=1 for this cycle only; return to INICIAL.
- Outputs hold their previous values between FINAL cycles, so the downstream stage never sees a mixed left/right pair.
- Divider and BCD counter clear on entry to every ESPERA state.
- Echo already high at ESPERA entry: treated as a rise (measurement starts immediately).

Optional Feature:
MEDIDOR_ARREDONDA_EN
- Defined: the tick divider preloads to CYCLES_PER_CM/2 (integer division) on ESPERA entry. Result = round-half-up(echo_cycles / CYCLES_PER_CM).
- Undefined: preload 0, floor behaviour.
- Saturation and timeout rules are unchanged in both cases.

Test Plan:
Bench parameters: TRIGGER_CYCLES=5, CYCLES_PER_CM=10, TIMEOUT_CYCLES=20000, PAUSA_CYCLES=20.
1. Reset released → `medida_esq`=`medida_dir`=12'h999, `pronto`=0, `db_estado`=0. Pulse `medir` → `trigger_esq` high exactly 5 cycles, `trigger_dir` low.
2. Left echo 50 cycles, right echo 127 cycles → single `pronto` pulse; `medida_esq`=12'h005. `medida_dir`=12'h012 without the macro, 12'h013 with it. Both timeout flags 0.
3. Left echo 1000 cycles → 12'h100 (BCD carry chain). Right echo 15000 cycles → 12'h999 (saturated), `timeout_dir`=0.
4. Left echo never rises → after 20000 cycles `medida_esq`=12'h999, `timeout_esq`=1. Right trigger still issued; normal right measurement completes.
5. `medir` pulsed during MEDE_DIR → ignored; exactly one `pronto`; outputs unchanged until FINAL.
6. `reset` asserted during MEDE_ESQ with `trigger_esq` previously active → triggers 0 immediately, outputs 12'h999, FSM INICIAL; a fresh `medir` completes normally.
